// File: rtl/hack_pkg.sv
// Shared types and widths for the Hack instruction-memory loader.
// IMEM_CHECKSUM_EN adds the checksum-verification states.
package hack_pkg;
  localparam int HACK_WORD_W = 16;
  localparam int LD_BYTE_W   = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_LO,
    ST_LOAD_HI,
    ST_RUN,
    ST_ERROR
`ifdef IMEM_CHECKSUM_EN
    ,
    ST_CHK_LO,
    ST_CHK_HI
`endif
  } imem_state_t;
endpackage

// File: rtl/imem_ram.sv
// Single-port program RAM: synchronous write, registered read with an
// output-register clear. The array itself is never reset.
module imem_ram
  import hack_pkg::*;
#(
  parameter int ADDR_W = 15
) (
  input  logic                   clk,
  input  logic                   we,
  input  logic                   re,
  input  logic                   clr,
  input  logic [ADDR_W-1:0]      addr,
  input  logic [HACK_WORD_W-1:0] wdata,
  output logic [HACK_WORD_W-1:0] rdata
);
  logic [HACK_WORD_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (clr)     rdata <= '0;
    else if (re) rdata <= mem[addr];
  end
endmodule

// File: rtl/imem_loader.sv
// Hack ROM responder and byte-stream program loader; holds the CPU in reset until
// a program is loaded. IMEM_CHECKSUM_EN enables a trailing checksum-word check.
module imem_loader
  import hack_pkg::*;
#(
  parameter int ADDR_W = 15
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load_start,
  input  logic                   run_start,
  input  logic                   ld_valid,
  output logic                   ld_ready,
  input  logic [LD_BYTE_W-1:0]   ld_byte,
  input  logic                   ld_last,
  input  logic [HACK_WORD_W-1:0] pc_addr,
  output logic [HACK_WORD_W-1:0] instr,
  output logic                   cpu_reset,
  output logic                   load_done,
  output logic                   load_err,
  output logic [ADDR_W:0]        word_count
);
  localparam logic [ADDR_W:0] DEPTH_CNT = {1'b1, {ADDR_W{1'b0}}};

  imem_state_t            state;
  imem_state_t            state_next;
  logic [LD_BYTE_W-1:0]   lo_byte;
  logic [HACK_WORD_W-1:0] wdata;
  logic [ADDR_W-1:0]      ram_addr;
  logic                   xfer;
  logic                   full;
  logic                   ram_we;
  logic                   ram_re;
  logic                   unused_pc_hi;

  assign xfer  = ld_valid && ld_ready;
  assign full  = (word_count == DEPTH_CNT);
  assign wdata = {ld_byte, lo_byte};

  // The memory has one port: PC address while running, write pointer otherwise.
  assign ram_addr     = (state == ST_RUN) ? pc_addr[ADDR_W-1:0] : word_count[ADDR_W-1:0];
  assign ram_we       = reset && !load_start && (state == ST_LOAD_HI) && xfer && !full;
  assign ram_re       = reset && (state == ST_RUN) && (state_next == ST_RUN);
  assign unused_pc_hi = ^pc_addr[HACK_WORD_W-1:ADDR_W];

`ifdef IMEM_CHECKSUM_EN
  logic [HACK_WORD_W-1:0] sum;
`endif

  always_comb begin
    state_next = state;
    if (load_start) begin
      state_next = ST_LOAD_LO;
    end else begin
      case (state)
        ST_IDLE:    if (run_start) state_next = ST_RUN;
        ST_LOAD_LO: if (xfer) state_next = ld_last ? ST_ERROR : ST_LOAD_HI;
        ST_LOAD_HI: begin
          if (xfer) begin
            if (full)         state_next = ST_ERROR;
`ifdef IMEM_CHECKSUM_EN
            else if (ld_last) state_next = ST_CHK_LO;
`else
            else if (ld_last) state_next = ST_RUN;
`endif
            else              state_next = ST_LOAD_LO;
          end
        end
`ifdef IMEM_CHECKSUM_EN
        ST_CHK_LO:  if (xfer) state_next = ST_CHK_HI;
        ST_CHK_HI:  if (xfer) state_next = (wdata == sum) ? ST_RUN : ST_ERROR;
`endif
        default:    state_next = state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= ST_IDLE;
      ld_ready   <= 1'b0;
      cpu_reset  <= 1'b1;
      load_done  <= 1'b0;
      load_err   <= 1'b0;
      word_count <= '0;
      lo_byte    <= '0;
`ifdef IMEM_CHECKSUM_EN
      sum        <= '0;
`endif
    end else begin
      state     <= state_next;
      cpu_reset <= (state_next != ST_RUN);
      load_done <= (state_next == ST_RUN);
      load_err  <= (state_next == ST_ERROR);
`ifdef IMEM_CHECKSUM_EN
      ld_ready  <= (state_next == ST_LOAD_LO) || (state_next == ST_LOAD_HI) ||
                   (state_next == ST_CHK_LO)  || (state_next == ST_CHK_HI);
`else
      ld_ready  <= (state_next == ST_LOAD_LO) || (state_next == ST_LOAD_HI);
`endif
      if (load_start) begin
        word_count <= '0;
`ifdef IMEM_CHECKSUM_EN
        sum        <= '0;
`endif
      end else if (xfer) begin
`ifdef IMEM_CHECKSUM_EN
        if (state == ST_LOAD_LO || state == ST_CHK_LO) lo_byte <= ld_byte;
`else
        if (state == ST_LOAD_LO) lo_byte <= ld_byte;
`endif
        // A full memory leaves the count saturated at DEPTH.
        if (state == ST_LOAD_HI && !full) begin
          word_count <= word_count + 1'b1;
`ifdef IMEM_CHECKSUM_EN
          sum        <= sum + wdata;
`endif
        end
      end
    end
  end

  imem_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .re    (ram_re),
    .clr   (!ram_re),
    .addr  (ram_addr),
    .wdata (wdata),
    .rdata (instr)
  );
endmodule
